// File: rtl/image_loader_if.sv
// Stream-in / byte-write-out bundle between the boot image source, image_loader
// and the CPU-side memories.
interface image_loader_if #(
  parameter int ADDR_W = 10
);
  logic              mode_i;
  logic              word_valid_i;
  logic [31:0]       word_i;
  logic              word_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_byte_o;
  logic [31:0]       hdr0_o;
  logic              hdr0_load_o;
  logic              done_o;
  logic              err_o;
  logic              cpu_rst_o;

  modport slave (
    input  mode_i, word_valid_i, word_i,
    output word_ready_o, mem_we_o, mem_addr_o, mem_byte_o,
           hdr0_o, hdr0_load_o, done_o, err_o, cpu_rst_o
  );

  modport master (
    output mode_i, word_valid_i, word_i,
    input  word_ready_o, mem_we_o, mem_addr_o, mem_byte_o,
           hdr0_o, hdr0_load_o, done_o, err_o, cpu_rst_o
  );
endinterface

// File: rtl/image_loader.sv
// Boot loader: parses a header+payload word stream, writes it big-endian into a
// byte memory (zero-filling the rest for data images), then releases the CPU.
module image_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  image_loader_if.slave bus
);
  // One spare bit so the write pointer can represent MEM_BYTES itself.
  localparam int              PW      = ADDR_W + 1;
  localparam logic [34:0]     MEM_LIM = 35'(MEM_BYTES);
  localparam logic [PW-1:0]   LAST    = PW'(MEM_BYTES - 1);

  typedef enum logic [2:0] {HDR0, HDR1, WORD, BYTE, FILL, DONE, ERR} state_t;

  state_t        state, state_d;
  logic          mode_q, mode_d;
  logic [31:0]   hdr0_q, hdr0_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    b_q, b_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [7:0]    byte_q, byte_d;
  logic          ld_q, ld_d;

  logic          ready, acc;
  logic [31:0]   base;
  logic [34:0]   span;

  assign ready = (state == HDR0) || (state == HDR1) || (state == WORD);
  assign acc   = ready && bus.word_valid_i;
  assign base  = mode_q ? 32'd0 : hdr0_q;
  // Extra headroom so base + 4*cnt can never wrap before the range compare.
  assign span  = {3'b000, base} + {1'b0, bus.word_i, 2'b00};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= HDR0;
      mode_q <= 1'b0;
      hdr0_q <= '0;
      rem_q  <= '0;
      word_q <= '0;
      b_q    <= '0;
      ptr_q  <= '0;
      we_q   <= 1'b0;
      byte_q <= '0;
      ld_q   <= 1'b0;
    end else begin
      state  <= state_d;
      mode_q <= mode_d;
      hdr0_q <= hdr0_d;
      rem_q  <= rem_d;
      word_q <= word_d;
      b_q    <= b_d;
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      byte_q <= byte_d;
      ld_q   <= ld_d;
    end
  end

  // Memory outputs are computed one cycle ahead so they stay registered and
  // line up with the state they belong to.
  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    hdr0_d  = hdr0_q;
    rem_d   = rem_q;
    word_d  = word_q;
    b_d     = b_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    byte_d  = 8'h00;
    ld_d    = 1'b0;
    case (state)
      HDR0: if (acc) begin
        hdr0_d  = bus.word_i;
        mode_d  = bus.mode_i;
        ld_d    = 1'b1;
        state_d = HDR1;
      end
      HDR1: if (acc) begin
        rem_d = bus.word_i;
        if ((!mode_q && hdr0_q[1:0] != 2'b00) || span > MEM_LIM) begin
          state_d = ERR;
        end else if (bus.word_i != 32'd0) begin
          ptr_d   = base[PW-1:0];
          state_d = WORD;
        end else if (mode_q) begin
          ptr_d   = '0;
          we_d    = 1'b1;
          state_d = FILL;
        end else begin
          state_d = DONE;
        end
      end
      WORD: if (acc) begin
        word_d  = bus.word_i;
        b_d     = 2'd0;
        we_d    = 1'b1;
        byte_d  = bus.word_i[31:24];
        state_d = BYTE;
      end
      BYTE: begin
        ptr_d = ptr_q + PW'(1);
        if (b_q != 2'd3) begin
          b_d    = b_q + 2'd1;
          we_d   = 1'b1;
          byte_d = word_q[5'd23 - 5'({b_q, 3'b000}) -: 8];
        end else begin
          rem_d = rem_q - 32'd1;
          if (rem_q != 32'd1) begin
            state_d = WORD;
          end else if (mode_q && ptr_q != LAST) begin
            we_d    = 1'b1;
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end
      end
      FILL: begin
        if (ptr_q == LAST) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + PW'(1);
          we_d  = 1'b1;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = HDR0;
    endcase
  end

  assign bus.word_ready_o = ready;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = ptr_q[ADDR_W-1:0];
  assign bus.mem_byte_o   = byte_q;
  assign bus.hdr0_o       = hdr0_q;
  assign bus.hdr0_load_o  = ld_q;
  assign bus.done_o       = (state == DONE);
  assign bus.err_o        = (state == ERR);
  assign bus.cpu_rst_o    = (state == DONE);
endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: expected byte writes are queued as each
// image is driven and popped by a write monitor.
module tb_image_loader;
  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 10;
  localparam int OW        = ADDR_W + 46;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  image_loader_if #(.ADDR_W(ADDR_W)) bus ();
  image_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  int          total  = 0;
  int          bad    = 0;
  int          wr_cnt = 0;
  int          ld_cnt = 0;
  wr_t         exp_q[$];
  logic [31:0] pay[$];

  localparam logic [OW-1:0] RST_VEC = {1'b1, 1'b0, {ADDR_W{1'b0}}, 8'h00, 32'h0, 4'b0000};

  function automatic logic [OW-1:0] outv();
    return {bus.word_ready_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_byte_o,
            bus.hdr0_o, bus.hdr0_load_o, bus.done_o, bus.err_o, bus.cpu_rst_o};
  endfunction

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.hdr0_load_o === 1'b1) ld_cnt++;
      if (bus.mem_we_o === 1'b1) begin
        wr_cnt++;
        total++;
        if (bus.word_ready_o !== 1'b0) begin
          bad++;
          $display("FAIL ready_during_write got=%b want=0 addr=%h", bus.word_ready_o, bus.mem_addr_o);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got addr=%h data=%h want none", bus.mem_addr_o, bus.mem_byte_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_addr_o, bus.mem_byte_o} !== e) begin
            bad++;
            $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                     bus.mem_addr_o, bus.mem_byte_o, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic expect_payload(input logic [31:0] base);
    logic [31:0] w;
    for (int k = 0; k < pay.size(); k++) begin
      w = pay[k];
      for (int b = 0; b < 4; b++)
        exp_q.push_back({ADDR_W'(base + 32'(4 * k + b)), w[31 - 8 * b -: 8]});
    end
  endtask

  task automatic expect_fill(input int from);
    for (int a = from; a < MEM_BYTES; a++) exp_q.push_back({ADDR_W'(a), 8'h00});
  endtask

  task automatic put(input logic [31:0] w);
    int n = 0;
    bus.word_i       = w;
    bus.word_valid_i = 1'b1;
    while (bus.word_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL put_timeout got ready=0 want ready=1 word=%h", w);
    end
    @(negedge clk);
  endtask

  task automatic send_image(input logic mode, input logic [31:0] h0, input logic [31:0] cnt,
                            input int gap);
    bus.mode_i = mode;
    put(h0);
    put(cnt);
    for (int k = 0; k < pay.size(); k++) begin
      if (gap > 0) begin
        bus.word_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
      end
      put(pay[k]);
    end
    bus.word_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (bus.done_o !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    #1;
    total++;
    if (bus.done_o !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout got done=%b want 1 after %0d cycles", bus.done_o, bound);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    bus.word_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (outv() !== RST_VEC) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", outv(), RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_instr();
    int w0 = wr_cnt, l0 = ld_cnt;
    pay = '{32'h2008_0005, 32'hFFFF_FFFF};
    expect_payload(32'h10);
    send_image(1'b0, 32'h10, 32'd2, 0);
    wait_done(50);
    total++;
    if ({bus.hdr0_o, bus.cpu_rst_o, bus.err_o} !== {32'h10, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL instr_final got hdr0=%h cpu_rst=%b err=%b want 10/1/0", bus.hdr0_o, bus.cpu_rst_o, bus.err_o);
    end
    total++;
    if (ld_cnt - l0 !== 1) begin
      bad++;
      $display("FAIL instr_hdr0_pulses got=%0d want=1", ld_cnt - l0);
    end
    total++;
    if (wr_cnt - w0 !== 8 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL instr_writes got=%0d left=%0d want=8 left=0", wr_cnt - w0, exp_q.size());
    end
    // words after completion are ignored
    bus.word_i = 32'h1234_5678;
    bus.word_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    bus.word_valid_i = 1'b0;
    #1;
    total++;
    if ({wr_cnt - w0, bus.done_o, bus.word_ready_o} !== {32'd8, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL done_ignores got writes=%0d done=%b ready=%b want 8/1/0", wr_cnt - w0, bus.done_o, bus.word_ready_o);
    end
  endtask

  task automatic test_data();
    int w0;
    do_reset();
    w0 = wr_cnt;
    pay = '{32'hDEAD_BEEF};
    expect_payload(32'h0);
    expect_fill(4);
    send_image(1'b1, 32'h400, 32'd1, 0);
    wait_done(3000);
    total++;
    if ({bus.hdr0_o, bus.cpu_rst_o} !== {32'h400, 1'b1}) begin
      bad++;
      $display("FAIL data_final got hdr0=%h cpu_rst=%b want 400/1", bus.hdr0_o, bus.cpu_rst_o);
    end
    total++;
    if (wr_cnt - w0 !== 1024 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL data_writes got=%0d left=%0d want=1024 left=0", wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_errors();
    int w0;
    do_reset();
    w0 = wr_cnt;
    pay.delete();
    send_image(1'b0, 32'h2, 32'd1, 0);
    bus.word_i = 32'hAAAA_5555;
    bus.word_valid_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.word_valid_i = 1'b0;
    #1;
    total++;
    if ({bus.err_o, bus.word_ready_o, bus.cpu_rst_o, bus.done_o, wr_cnt - w0} !== {4'b1000, 32'd0}) begin
      bad++;
      $display("FAIL misalign got err=%b ready=%b cpu_rst=%b done=%b writes=%0d want 1/0/0/0/0",
               bus.err_o, bus.word_ready_o, bus.cpu_rst_o, bus.done_o, wr_cnt - w0);
    end
    do_reset();
    w0 = wr_cnt;
    send_image(1'b0, 32'h3FC, 32'd2, 0);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({bus.err_o, bus.word_ready_o, bus.cpu_rst_o, wr_cnt - w0} !== {3'b100, 32'd0}) begin
      bad++;
      $display("FAIL range_over got err=%b ready=%b cpu_rst=%b writes=%0d want 1/0/0/0",
               bus.err_o, bus.word_ready_o, bus.cpu_rst_o, wr_cnt - w0);
    end
    do_reset();
    w0 = wr_cnt;
    pay = '{32'hA1B2_C3D4};
    expect_payload(32'h3FC);
    send_image(1'b0, 32'h3FC, 32'd1, 0);
    wait_done(50);
    total++;
    if ({bus.err_o, wr_cnt - w0} !== {1'b0, 32'd4} || exp_q.size() != 0) begin
      bad++;
      $display("FAIL range_edge got err=%b writes=%0d left=%0d want 0/4/0", bus.err_o, wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int w0;
    do_reset();
    w0 = wr_cnt;
    pay = '{32'h2008_0005, 32'hFFFF_FFFF, 32'h0123_4567};
    expect_payload(32'h10);
    send_image(1'b0, 32'h10, 32'd3, 2);
    wait_done(100);
    total++;
    if (wr_cnt - w0 !== 12 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_writes got=%0d left=%0d want=12 left=0", wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int w0, n;
    do_reset();
    w0 = wr_cnt;
    exp_q.push_back({ADDR_W'(32'h80), 8'h11});
    exp_q.push_back({ADDR_W'(32'h81), 8'h22});
    exp_q.push_back({ADDR_W'(32'h82), 8'h33});
    bus.mode_i = 1'b0;
    put(32'h80);
    put(32'd2);
    put(32'h1122_3344);
    bus.word_valid_i = 1'b0;
    n = 0;
    while (wr_cnt - w0 < 3 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outv() !== RST_VEC || wr_cnt - w0 !== 3) begin
      bad++;
      $display("FAIL mid_reset got=%h writes=%0d want=%h writes=3", outv(), wr_cnt - w0, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pay = '{32'hCAFE_F00D};
    expect_payload(32'h20);
    send_image(1'b0, 32'h20, 32'd1, 0);
    wait_done(50);
    total++;
    if (bus.hdr0_o !== 32'h20 || exp_q.size() != 0 || wr_cnt - w0 !== 7) begin
      bad++;
      $display("FAIL reload got hdr0=%h left=%0d writes=%0d want 20/0/7", bus.hdr0_o, exp_q.size(), wr_cnt - w0);
    end
  endtask

  initial begin
    bus.mode_i       = 1'b0;
    bus.word_valid_i = 1'b0;
    bus.word_i       = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_instr();
    test_data();
    test_errors();
    test_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
